// File: rtl/not_gate_auto_checker.sv
// Drives an incrementing vector into an inverter and checks that dut_out is its bitwise inverse.
// Latency: done rises NUM_VECTORS*(SETTLE+1) cycles after start is sampled; start is ignored while busy.
// Optional NOT_CHECK_STOP_ON_ERR_EN: end the run on the first mismatch.
module not_gate_auto_checker #(
  parameter int WIDTH       = 1,
  parameter int SETTLE      = 2,
  parameter int NUM_VECTORS = 16,
  parameter int CNT_W       = 8,
  parameter int VC_W        = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dut_out,
  output logic [WIDTH-1:0] stim_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_count,
  output logic [VC_W-1:0]  vec_count
);

  localparam int SC_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [SC_W-1:0] SETTLE_LAST = SC_W'(SETTLE - 1);
  localparam logic [VC_W-1:0] VEC_LAST    = VC_W'(NUM_VECTORS - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_CHECK,
    ST_DONE
  } state_t;

  state_t          state, state_n;
  logic [SC_W-1:0] settle_cnt, settle_n;
  logic [WIDTH-1:0] stim_n;
  logic [CNT_W-1:0] err_n;
  logic [VC_W-1:0]  vec_n;
  logic             mismatch;
  logic             last_vec;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      settle_cnt <= '0;
      stim_out   <= '0;
      err_count  <= '0;
      vec_count  <= '0;
    end else begin
      state      <= state_n;
      settle_cnt <= settle_n;
      stim_out   <= stim_n;
      err_count  <= err_n;
      vec_count  <= vec_n;
    end
  end

  // The registered vector is compared, so a combinational DUT has had the whole settle window.
  assign mismatch = (dut_out != ~stim_out);
  assign last_vec = (vec_count == VEC_LAST);

  always_comb begin
    state_n  = state;
    settle_n = settle_cnt;
    stim_n   = stim_out;
    err_n    = err_count;
    vec_n    = vec_count;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_n  = ST_SETTLE;
          settle_n = '0;
          stim_n   = '0;
          err_n    = '0;
          vec_n    = '0;
        end
      end
      ST_SETTLE: begin
        if (settle_cnt == SETTLE_LAST) begin
          state_n = ST_CHECK;
        end else begin
          settle_n = settle_cnt + SC_W'(1);
        end
      end
      ST_CHECK: begin
        if (mismatch && (err_count != {CNT_W{1'b1}})) begin
          err_n = err_count + CNT_W'(1);
        end
        vec_n = vec_count + VC_W'(1);
`ifdef NOT_CHECK_STOP_ON_ERR_EN
        if (last_vec || mismatch) begin
`else
        if (last_vec) begin
`endif
          state_n = ST_DONE;
        end else begin
          state_n  = ST_SETTLE;
          settle_n = '0;
          stim_n   = stim_out + WIDTH'(1);
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  assign busy = (state == ST_SETTLE) || (state == ST_CHECK);
  assign done = (state == ST_DONE);
  assign pass = done && (err_count == '0);

endmodule
